// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit LCD writer: runs the power-on init sequence, then sends each
// byte accepted on the CPU ready/strobe handshake as two timed nibble writes.
module lcd_byte_writer #(
  parameter int unsigned P_POWERUP    = 750000,
  parameter int unsigned P_INIT_LONG  = 205000,
  parameter int unsigned P_INIT_MID   = 5000,
  parameter int unsigned P_CMD_WAIT   = 2000,
  parameter int unsigned P_CLEAR_WAIT = 82000,
  parameter int unsigned P_SETUP      = 2,
  parameter int unsigned P_EN_PULSE   = 12,
  parameter int unsigned P_HOLD       = 1,
  parameter int unsigned P_NIBBLE_GAP = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iCommand,
  input  logic       iData_Ready,
  output logic       oReadyForData,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_StrataFlashControl,
  output logic       oLCD_ReadWrite,
  output logic [3:0] oLCD_Data
);

  function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned CntMax = maxOf(P_POWERUP, maxOf(P_INIT_LONG, maxOf(P_CLEAR_WAIT,
                                   maxOf(P_INIT_MID, maxOf(P_CMD_WAIT, P_NIBBLE_GAP)))));
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned SeqW   = 4;

  localparam logic [2:0] stPowerup = 3'd0;
  localparam logic [2:0] stSetup   = 3'd1;
  localparam logic [2:0] stEnHi    = 3'd2;
  localparam logic [2:0] stHold    = 3'd3;
  localparam logic [2:0] stGap     = 3'd4;
  localparam logic [2:0] stWait    = 3'd5;
  localparam logic [2:0] stIdle    = 3'd6;

  // Steps 0-3 are single init nibbles (upper half of the byte), 4-7 config bytes, 8 = user bytes.
  function automatic logic [7:0] stepByte(input logic [SeqW-1:0] s);
    case (s)
      4'd0, 4'd1, 4'd2: return 8'h30;
      4'd3:             return 8'h20;
      4'd4:             return 8'h28;
      4'd5:             return 8'h06;
      4'd6:             return 8'h0C;
      4'd7:             return 8'h01;
      default:          return 8'h00;
    endcase
  endfunction

  function automatic logic [CntW-1:0] initWait(input logic [SeqW-1:0] s);
    case (s)
      4'd0:    return CntW'(P_INIT_LONG - 1);
      4'd1:    return CntW'(P_INIT_MID - 1);
      default: return CntW'(P_CMD_WAIT - 1);
    endcase
  endfunction

  logic [2:0]      state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic [SeqW-1:0] seq, seqNext;
  logic [7:0]      byteReg, byteNext;
  logic            rsReg, rsNext;
  logic            lowReg, lowNext;
  logic            cntZero;
  logic [CntW-1:0] cntDec;

  assign cntZero = (cnt == '0);
  assign cntDec  = cnt - CntW'(1);

  assign oLCD_StrataFlashControl = 1'b1;
  assign oLCD_ReadWrite          = 1'b0;

  // State, timer and registered LCD/handshake outputs
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state               <= stPowerup;
      cnt                 <= CntW'(P_POWERUP - 1);
      seq                 <= '0;
      byteReg             <= '0;
      rsReg               <= 1'b0;
      lowReg              <= 1'b0;
      oReadyForData       <= 1'b0;
      oLCD_Enabled        <= 1'b0;
      oLCD_RegisterSelect <= 1'b0;
      oLCD_Data           <= '0;
    end else begin
      state               <= stateNext;
      cnt                 <= cntNext;
      seq                 <= seqNext;
      byteReg             <= byteNext;
      rsReg               <= rsNext;
      lowReg              <= lowNext;
      oReadyForData       <= (stateNext == stIdle);
      oLCD_Enabled        <= (stateNext == stEnHi);
      oLCD_RegisterSelect <= rsNext;
      oLCD_Data           <= lowNext ? byteNext[3:0] : byteNext[7:4];
    end
  end

  // Next-state logic; every wait loads N-1 on entry so it lasts exactly N cycles
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    seqNext   = seq;
    byteNext  = byteReg;
    rsNext    = rsReg;
    lowNext   = lowReg;
    case (state)
      stPowerup: begin
        if (cntZero) begin
          stateNext = stSetup;
          cntNext   = CntW'(P_SETUP - 1);
          byteNext  = stepByte(seq);
          rsNext    = 1'b0;
          lowNext   = 1'b0;
        end else cntNext = cntDec;
      end
      stSetup: begin
        if (cntZero) begin
          stateNext = stEnHi;
          cntNext   = CntW'(P_EN_PULSE - 1);
        end else cntNext = cntDec;
      end
      stEnHi: begin
        if (cntZero) begin
          stateNext = stHold;
          cntNext   = CntW'(P_HOLD - 1);
        end else cntNext = cntDec;
      end
      stHold: begin
        if (cntZero) begin
          if (seq < SeqW'(4)) begin
            stateNext = stWait;
            cntNext   = initWait(seq);
          end else if (!lowReg) begin
            stateNext = stGap;
            cntNext   = CntW'(P_NIBBLE_GAP - 1);
          end else begin
            stateNext = stWait;
            cntNext   = (!rsReg && byteReg == 8'h01) ? CntW'(P_CLEAR_WAIT - 1)
                                                     : CntW'(P_CMD_WAIT - 1);
          end
        end else cntNext = cntDec;
      end
      stGap: begin
        if (cntZero) begin
          stateNext = stSetup;
          cntNext   = CntW'(P_SETUP - 1);
          lowNext   = 1'b1;
        end else cntNext = cntDec;
      end
      stWait: begin
        if (cntZero) begin
          if (seq >= SeqW'(7)) begin
            stateNext = stIdle;
            seqNext   = SeqW'(8);
          end else begin
            stateNext = stSetup;
            seqNext   = seq + SeqW'(1);
            cntNext   = CntW'(P_SETUP - 1);
            byteNext  = stepByte(seq + SeqW'(1));
            rsNext    = 1'b0;
            lowNext   = 1'b0;
          end
        end else cntNext = cntDec;
      end
      stIdle: begin
        if (iData_Ready) begin
          stateNext = stSetup;
          cntNext   = CntW'(P_SETUP - 1);
          byteNext  = iData;
          rsNext    = ~iCommand;
          lowNext   = 1'b0;
        end
      end
      default: begin
        stateNext = stPowerup;
        cntNext   = CntW'(P_POWERUP - 1);
        seqNext   = '0;
      end
    endcase
  end

endmodule
